regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port among N_REQ writeback requesters (ALU, load unit, move/immediate unit) using round-robin arbitration and valid/ready handshakes. It drives regWrite/writeReg/writeData from registered outputs, one write per cycle. A 16-entry pending-write scoreboard marks destination registers as busy from issue until their writeback is granted, so the decode stage can stall on hazards.

Parameters:
N_REQ, 3, number of writeback requesters (2..4)
DATA_W, 18, register data width
REG_AW, 4, register address width (2**REG_AW registers)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  requester i has a write pending
req_reg  in  N_REQ*REG_AW  destination of requester i at [i*REG_AW +: REG_AW]
req_data  in  N_REQ*DATA_W  write data of requester i at [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
reserve_valid  in  1  issue stage reserves a destination register
reserve_reg  in  REG_AW  register being reserved
busy  out  2**REG_AW  scoreboard; bit r = write to r pending
reserve_err  out  1  sticky; reserve of an already-busy register
regWrite  out  1  to register file write enable
writeReg  out  REG_AW  to register file write address
writeData  out  DATA_W  to register file write data

Behaviour:
- Reset (synchronous, evaluated at clk edge): regWrite=0, writeReg=0, writeData=0, busy=0, reserve_err=0, RR pointer=0. req_ready is combinational and reads 0 while reset is high.
- Arbitration: combinational. Search starts at index ptr and proceeds ptr, ptr+1, ..., wrapping modulo N_REQ. The first requester with valid set is granted. At most one req_ready bit is high. req_ready is 0 when no valid is set.
- req_ready[i] depends only on req_valid and ptr. There is no valid-to-ready dependency on other inputs.
- Requesters hold valid, reg and data stable until granted. A requester may not withdraw a request.
- On grant of requester g: ptr <= (g+1) mod N_REQ. With no grant, ptr holds.
- Latency: the granted request appears on regWrite/writeReg/writeData the next cycle. The register file commits it on the following edge. regWrite=1 for exactly one cycle per grant. Back-to-back grants give back-to-back writes.
- No grant: regWrite=0. writeReg/writeData hold their last values.
- Scoreboard set: reserve_valid sets busy[reserve_reg] on the next edge.
- Scoreboard clear: a grant to register r clears busy[r] on the next edge, the same edge that registers the write.
- Same-cycle reserve and grant on the same register: the set wins and busy stays 1 (a new writer is in flight).
- Reserve of a register that is already busy and not cleared that cycle: busy stays 1, reserve_err <= 1 (sticky until reset).
- A grant to a register that is not busy is legal (untracked write): busy unchanged, no error.
- Two requesters targeting the same register: granted in round-robin order. The last grant's data lands last.
- Reset asserted mid-operation: pending requests are dropped and the scoreboard is cleared. A write already registered is not emitted, because regWrite goes to 0 at the reset edge.

Optional Feature:
RFARB_STATS_EN — when defined, the block adds these output ports:
- conflict_cnt (16 bits): saturating count of cycles with two or more req_valid bits set.
- grant_cnt (N_REQ*16 bits): saturating grants per requester.

All counters reset to 0 and stick at 16'hFFFF. When the macro is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package rf_pkg holds:
  - constants RF_DATA_W=18, RF_AW=4, RF_NREGS=16;
  - typedefs rf_addr_t and rf_data_t.
- One sub-module, rr_arbiter (N parameter), provides the combinational one-hot grant from req and ptr, and the next-ptr computation.
- The scoreboard and output registers stay in the top module.

Test Plan:
- Single request: reset, then req_valid=3'b001, req_reg[0]=5, data=18'h2A5A. Expect req_ready=001 in the same cycle, then regWrite=1, writeReg=5, writeData=18'h2A5A one cycle later, then regWrite=0.
- Round-robin: all three valid continuously for 6 cycles, ptr=0 at start. Expect grants 0,1,2,0,1,2 and six consecutive regWrite pulses in that order.
- Scoreboard: reserve r3, then r7. Expect busy=16'h0088. Grant a write to r3. Expect busy=16'h0080 on the edge after the grant.
- Simultaneous: with busy[4]=1, reserve r4 in the same cycle as a grant to r4. Expect busy[4]=1 and reserve_err=0. Then reserve r4 again with no grant. Expect reserve_err=1, held until reset.
- Reset mid-stream: requester 1 valid and granted in cycle k, reset high in cycle k+1. Expect regWrite=0, busy=0, ptr=0 after the reset edge, and req_ready=0 while reset is high.
- With RFARB_STATS_EN: hold two requesters valid for 70000 cycles. Expect conflict_cnt=16'hFFFF (saturated) and both grant counters = 35000.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_pkg;

  localparam int RF_DATA_W = 18;
  localparam int RF_AW     = 4;
  localparam int RF_NREGS  = 16;

  typedef logic [RF_AW-1:0]     rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester bus: packed per-requester valid/reg/data plus one-hot ready.
// Handshake: a requester raises req_valid[i] with req_reg/req_data held stable; the
// transfer happens on the clock edge where req_valid[i] && req_ready[i]; no withdrawal.
interface regfile_write_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 18,
  parameter int REG_AW = 4
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*REG_AW-1:0] req_reg;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_reg,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_reg,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching from ptr upward with
// wrap-around, the granted index, and the pointer to use after this grant.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any,
  output logic [PW-1:0] next_ptr
);

  int c;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    any       = 1'b0;
    c         = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[PW'(c)]) begin
        grant[PW'(c)] = 1'b1;
        grant_idx     = PW'(c);
        any           = 1'b1;
      end
    end
  end

  always_comb begin
    next_ptr = ptr;
    if (any) begin
      if (grant_idx == PW'(N - 1)) next_ptr = '0;
      else                         next_ptr = grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port with a pending-write
// scoreboard. Optional RFARB_STATS_EN adds saturating conflict/grant counters.
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = RF_DATA_W,
  parameter int REG_AW = RF_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave req,
  input  logic                   reserve_valid,
  input  logic [REG_AW-1:0]      reserve_reg,
  output logic [2**REG_AW-1:0]   busy,
  output logic                   reserve_err,
  output logic                   regWrite,
  output logic [REG_AW-1:0]      writeReg,
  output logic [DATA_W-1:0]      writeData,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] rr_ptr
`ifdef RFARB_STATS_EN
  ,
  output logic [15:0]            conflict_cnt,
  output logic [N_REQ*16-1:0]    grant_cnt
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    grant;
  logic [PW-1:0]       grant_idx;
  logic                grant_any;
  logic [PW-1:0]       next_ptr;
  logic                fire;
  logic [REG_AW-1:0]   grant_reg;
  logic [DATA_W-1:0]   grant_data;
  logic [2**REG_AW-1:0] busy_next;
  logic                err_set;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req       (req.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any),
    .next_ptr  (next_ptr)
  );

  // Ready is suppressed during reset so nothing transfers on a reset edge.
  assign req.req_ready = reset ? '0 : grant;
  assign fire          = grant_any && !reset;
  assign grant_reg     = req.req_reg[grant_idx*REG_AW +: REG_AW];
  assign grant_data    = req.req_data[grant_idx*DATA_W +: DATA_W];

  // Clear first, then set: a reserve on the register being written keeps it busy.
  always_comb begin
    busy_next = busy;
    if (fire) busy_next[grant_reg] = 1'b0;
    if (reserve_valid) busy_next[reserve_reg] = 1'b1;
  end

  assign err_set = reserve_valid && busy[reserve_reg] &&
                   !(fire && (grant_reg == reserve_reg));

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite    <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
      busy        <= '0;
      reserve_err <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      regWrite <= fire;
      if (fire) begin
        writeReg  <= grant_reg;
        writeData <= grant_data;
        rr_ptr    <= next_ptr;
      end
      busy <= busy_next;
      if (err_set) reserve_err <= 1'b1;
    end
  end

`ifdef RFARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
      grant_cnt    <= '0;
    end else begin
      if (($countones(req.req_valid) >= 2) && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
      for (int i = 0; i < N_REQ; i++) begin
        if (fire && grant[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF))
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; stats checks run when RFARB_STATS_EN is set.
module tb_regfile_write_arbiter;
  import rf_pkg::*;

  logic          clk;
  logic          reset;
  logic          reserve_valid;
  rf_addr_t      reserve_reg;
  logic [15:0]   busy;
  logic          reserve_err;
  logic          regWrite;
  rf_addr_t      writeReg;
  rf_data_t      writeData;
  logic [1:0]    rr_ptr;
`ifdef RFARB_STATS_EN
  logic [15:0]   conflict_cnt;
  logic [47:0]   grant_cnt;
`endif

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter_if #(.N_REQ(3), .DATA_W(18), .REG_AW(4)) rq ();

  regfile_write_arbiter #(.N_REQ(3), .DATA_W(18), .REG_AW(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (rq),
    .reserve_valid (reserve_valid),
    .reserve_reg   (reserve_reg),
    .busy          (busy),
    .reserve_err   (reserve_err),
    .regWrite      (regWrite),
    .writeReg      (writeReg),
    .writeData     (writeData),
    .rr_ptr        (rr_ptr)
`ifdef RFARB_STATS_EN
    ,
    .conflict_cnt  (conflict_cnt),
    .grant_cnt     (grant_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input rf_addr_t r, input rf_data_t d);
    rq.req_reg[i*4 +: 4]   = r;
    rq.req_data[i*18 +: 18] = d;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    rq.req_valid  = '0;
    rq.req_reg    = '0;
    rq.req_data   = '0;
    reserve_valid = 1'b0;
    reserve_reg   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    rq.req_valid = 3'b111;
    #1;
    checks++;
    if (rq.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", rq.req_ready); end
    tick();
    checks++;
    if (regWrite !== 1'b0 || writeReg !== 4'd0 || writeData !== 18'd0) begin
      errors++; $display("FAIL reset_outputs: got we=%b reg=%h data=%h expected 0/0/0", regWrite, writeReg, writeData);
    end
    checks++;
    if (busy !== 16'h0000 || reserve_err !== 1'b0 || rr_ptr !== 2'd0) begin
      errors++; $display("FAIL reset_state: got busy=%h err=%b ptr=%0d expected 0/0/0", busy, reserve_err, rr_ptr);
    end
    rq.req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 4'd5, 18'h2A5A);
    rq.req_valid = 3'b001;
    #1;
    checks++;
    if (rq.req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected 001", rq.req_ready); end
    tick();
    rq.req_valid = '0;
    checks++;
    if (regWrite !== 1'b1 || writeReg !== 4'd5 || writeData !== 18'h2A5A) begin
      errors++; $display("FAIL single_write: got we=%b reg=%h data=%h expected 1/5/2a5a", regWrite, writeReg, writeData);
    end
    tick();
    checks++;
    if (regWrite !== 1'b0 || writeReg !== 4'd5 || writeData !== 18'h2A5A) begin
      errors++; $display("FAIL single_idle: got we=%b reg=%h data=%h expected 0/5/2a5a", regWrite, writeReg, writeData);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ready [6];
    int exp_g [6];
    exp_g = '{0, 1, 2, 0, 1, 2};
    exp_ready = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, rf_addr_t'(i + 1), rf_data_t'(18'h100 + i));
    rq.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (rq.req_ready !== exp_ready[k]) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, rq.req_ready, exp_ready[k]);
      end
      tick();
      checks++;
      if (regWrite !== 1'b1 || writeReg !== rf_addr_t'(exp_g[k] + 1) || writeData !== rf_data_t'(18'h100 + exp_g[k])) begin
        errors++; $display("FAIL rr_write[%0d]: got we=%b reg=%h data=%h expected 1/%h/%h",
                           k, regWrite, writeReg, writeData, exp_g[k] + 1, 18'h100 + exp_g[k]);
      end
    end
    rq.req_valid = '0;
    tick();
    checks++;
    if (regWrite !== 1'b0) begin errors++; $display("FAIL rr_idle: got we=%b expected 0", regWrite); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    reserve_valid = 1'b1;
    reserve_reg   = 4'd3;
    tick();
    reserve_reg   = 4'd7;
    tick();
    reserve_valid = 1'b0;
    checks++;
    if (busy !== 16'h0088) begin errors++; $display("FAIL sb_reserve: got busy=%h expected 0088", busy); end
    set_req(0, 4'd3, 18'h00333);
    rq.req_valid = 3'b001;
    tick();
    rq.req_valid = '0;
    checks++;
    if (busy !== 16'h0080 || regWrite !== 1'b1 || writeReg !== 4'd3) begin
      errors++; $display("FAIL sb_clear: got busy=%h we=%b reg=%h expected 0080/1/3", busy, regWrite, writeReg);
    end
    set_req(0, 4'd9, 18'h00999);
    rq.req_valid = 3'b001;
    tick();
    rq.req_valid = '0;
    checks++;
    if (busy !== 16'h0080 || reserve_err !== 1'b0 || writeReg !== 4'd9 || rr_ptr !== 2'd1) begin
      errors++; $display("FAIL sb_untracked: got busy=%h err=%b reg=%h ptr=%0d expected 0080/0/9/1",
                         busy, reserve_err, writeReg, rr_ptr);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    reserve_valid = 1'b1;
    reserve_reg   = 4'd4;
    tick();
    checks++;
    if (busy !== 16'h0010) begin errors++; $display("FAIL sim_setup: got busy=%h expected 0010", busy); end
    set_req(1, 4'd4, 18'h04444);
    rq.req_valid = 3'b010;
    #1;
    checks++;
    if (rq.req_ready !== 3'b010) begin errors++; $display("FAIL sim_ready: got %b expected 010", rq.req_ready); end
    tick();
    rq.req_valid = '0;
    checks++;
    if (busy !== 16'h0010 || reserve_err !== 1'b0 || regWrite !== 1'b1) begin
      errors++; $display("FAIL sim_set_wins: got busy=%h err=%b we=%b expected 0010/0/1", busy, reserve_err, regWrite);
    end
    tick();
    reserve_valid = 1'b0;
    checks++;
    if (reserve_err !== 1'b1 || busy !== 16'h0010) begin
      errors++; $display("FAIL sim_err_set: got err=%b busy=%h expected 1/0010", reserve_err, busy);
    end
    tick();
    tick();
    tick();
    checks++;
    if (reserve_err !== 1'b1) begin errors++; $display("FAIL sim_err_sticky: got err=%b expected 1", reserve_err); end
    do_reset();
    checks++;
    if (reserve_err !== 1'b0) begin errors++; $display("FAIL sim_err_reset: got err=%b expected 0", reserve_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    reserve_valid = 1'b1;
    reserve_reg   = 4'd5;
    tick();
    reserve_valid = 1'b0;
    set_req(0, 4'd0, 18'h00001);
    rq.req_valid = 3'b001;
    tick();
    set_req(1, 4'd2, 18'h03C3C);
    set_req(2, 4'd8, 18'h08888);
    rq.req_valid = 3'b110;
    #1;
    checks++;
    if (rq.req_ready !== 3'b010) begin errors++; $display("FAIL mid_ready: got %b expected 010", rq.req_ready); end
    tick();
    checks++;
    if (regWrite !== 1'b1 || writeReg !== 4'd2 || writeData !== 18'h03C3C) begin
      errors++; $display("FAIL mid_write: got we=%b reg=%h data=%h expected 1/2/3c3c", regWrite, writeReg, writeData);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rq.req_ready !== 3'b000) begin errors++; $display("FAIL mid_ready_rst: got %b expected 000", rq.req_ready); end
    tick();
    checks++;
    if (regWrite !== 1'b0 || busy !== 16'h0000 || rr_ptr !== 2'd0) begin
      errors++; $display("FAIL mid_after_rst: got we=%b busy=%h ptr=%0d expected 0/0000/0", regWrite, busy, rr_ptr);
    end
    rq.req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_same_reg();
    do_reset();
    set_req(0, 4'd6, 18'h1AAAA);
    set_req(2, 4'd6, 18'h25555);
    rq.req_valid = 3'b101;
    #1;
    checks++;
    if (rq.req_ready !== 3'b001) begin errors++; $display("FAIL same_ready0: got %b expected 001", rq.req_ready); end
    tick();
    rq.req_valid = 3'b100;
    checks++;
    if (writeData !== 18'h1AAAA) begin errors++; $display("FAIL same_first: got data=%h expected 1aaaa", writeData); end
    #1;
    checks++;
    if (rq.req_ready !== 3'b100) begin errors++; $display("FAIL same_ready2: got %b expected 100", rq.req_ready); end
    tick();
    rq.req_valid = '0;
    tick();
    checks++;
    if (regWrite !== 1'b0 || writeReg !== 4'd6 || writeData !== 18'h25555) begin
      errors++; $display("FAIL same_last: got we=%b reg=%h data=%h expected 0/6/25555", regWrite, writeReg, writeData);
    end
  endtask

`ifdef RFARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_req(0, 4'd1, 18'h00011);
    set_req(1, 4'd2, 18'h00022);
    rq.req_valid = 3'b011;
    for (int k = 0; k < 70000; k++) tick();
    rq.req_valid = '0;
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_conflict: got %h expected ffff", conflict_cnt); end
    checks++;
    if (grant_cnt[15:0] !== 16'd35000 || grant_cnt[31:16] !== 16'd35000 || grant_cnt[47:32] !== 16'd0) begin
      errors++; $display("FAIL stats_grants: got %0d/%0d/%0d expected 35000/35000/0",
                         grant_cnt[15:0], grant_cnt[31:16], grant_cnt[47:32]);
    end
  endtask
`endif

  initial begin
    reset         = 1'b1;
    rq.req_valid  = '0;
    rq.req_reg    = '0;
    rq.req_data   = '0;
    reserve_valid = 1'b0;
    reserve_reg   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_scoreboard();
    test_simultaneous();
    test_reset_mid();
    test_same_reg();
`ifdef RFARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
